// File: rtl/plic_claim_master_pkg.sv
// Shared configuration for the PLIC claim/complete sequencer: Wishbone widths,
// PLIC register addresses, FSM state encoding and interrupt ID values.
`ifndef PERIPS_CFG_VH
`define PERIPS_CFG_VH
`define WB_AD_WIDTH        32
`define WB_DAT_WIDTH       32
`define IRQ_RESPONSE_ADDR  32'h0C20_0004
`define IRQ_COMPLETE_ADDR  32'h0C20_0008
`define PLIC_ST_IDLE       3'd0
`define PLIC_ST_ARB_C      3'd1
`define PLIC_ST_CLAIM      3'd2
`define PLIC_ST_DISPATCH   3'd3
`define PLIC_ST_SERVICE    3'd4
`define PLIC_ST_ARB_W      3'd5
`define PLIC_ST_COMPLETE   3'd6
`define PLIC_ST_HOLD       3'd7
`define IRQ_ID_NONE        2'd0
`define IRQ_ID_UART        2'd1
`define IRQ_ID_GPIO        2'd2
`endif

package plic_claim_master_pkg;
  localparam int WB_AW = `WB_AD_WIDTH;
  localparam int WB_DW = `WB_DAT_WIDTH;
  localparam int WB_SW = `WB_DAT_WIDTH / 8;

  localparam logic [WB_AW-1:0] DEF_CLAIM_ADDR    = `IRQ_RESPONSE_ADDR;
  localparam logic [WB_AW-1:0] DEF_COMPLETE_ADDR = `IRQ_COMPLETE_ADDR;

  localparam logic [2:0] S_IDLE     = `PLIC_ST_IDLE;
  localparam logic [2:0] S_ARB_C    = `PLIC_ST_ARB_C;
  localparam logic [2:0] S_CLAIM    = `PLIC_ST_CLAIM;
  localparam logic [2:0] S_DISPATCH = `PLIC_ST_DISPATCH;
  localparam logic [2:0] S_SERVICE  = `PLIC_ST_SERVICE;
  localparam logic [2:0] S_ARB_W    = `PLIC_ST_ARB_W;
  localparam logic [2:0] S_COMPLETE = `PLIC_ST_COMPLETE;
  localparam logic [2:0] S_HOLD     = `PLIC_ST_HOLD;

  localparam logic [1:0] IRQ_ID_NONE = `IRQ_ID_NONE;
  localparam logic [1:0] IRQ_ID_UART = `IRQ_ID_UART;
  localparam logic [1:0] IRQ_ID_GPIO = `IRQ_ID_GPIO;
endpackage

// File: rtl/wb_single_master.sv
// Single-beat Wishbone initiator: launches one registered cycle on i_start and
// ends it on ack or after TIMEOUT cycles without ack.
module wb_single_master
  import plic_claim_master_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_we,
  input  logic [WB_AW-1:0] i_addr,
  input  logic [WB_DW-1:0] i_wdata,
  input  logic             i_ack,
  output logic             o_cyc,
  output logic             o_stb,
  output logic             o_we,
  output logic [WB_AW-1:0] o_addr,
  output logic [WB_DW-1:0] o_wdata,
  output logic [WB_SW-1:0] o_sel,
  output logic             o_done,
  output logic             o_timeout
);
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  logic             r_cyc;
  logic             r_we;
  logic [WB_AW-1:0] r_addr;
  logic [WB_DW-1:0] r_wdata;
  logic [WB_SW-1:0] r_sel;
  logic [7:0]       r_cnt;
  logic             w_end;

  // An ack arriving in the last allowed cycle still counts as success.
  assign o_done    = r_cyc & i_ack;
  assign o_timeout = r_cyc & ~i_ack & (r_cnt == LAST_CNT);
  assign w_end     = o_done | o_timeout;

  always_ff @(posedge clk) begin
    if (rst || w_end) begin
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
    end else if (i_start && !r_cyc) begin
      r_cyc   <= 1'b1;
      r_we    <= i_we;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
      r_sel   <= '1;
      r_cnt   <= '0;
    end else if (r_cyc) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_cyc   = r_cyc;
  assign o_stb   = r_cyc;
  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
  assign o_sel   = r_sel;
endmodule

// File: rtl/plic_claim_master.sv
// Core-side PLIC claim/complete sequencer: claims an interrupt over Wishbone,
// hands the ID to the core, and writes it back to the complete register.
module plic_claim_master
  import plic_claim_master_pkg::*;
#(
  parameter logic [WB_AW-1:0] CLAIM_ADDR    = DEF_CLAIM_ADDR,
  parameter logic [WB_AW-1:0] COMPLETE_ADDR = DEF_COMPLETE_ADDR,
  parameter int               TIMEOUT       = 255,
  parameter int               HOLDOFF       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             plic_core_ext_irq_i,
  input  logic             irq_en_i,
  output logic             bus_req_o,
  input  logic             bus_gnt_i,
  output logic             wbm_plic_cyc_o,
  output logic             wbm_plic_stb_o,
  output logic             wbm_plic_we_o,
  output logic [WB_AW-1:0] wbm_plic_addr_o,
  output logic [WB_DW-1:0] wbm_plic_wdata_o,
  output logic [WB_SW-1:0] wbm_plic_sel_o,
  input  logic [WB_DW-1:0] plic_wbm_rdata_i,
  input  logic             plic_wbm_ack_i,
  output logic             irq_valid_o,
  output logic [1:0]       irq_id_o,
  input  logic             irq_ready_i,
  input  logic             irq_done_i,
  output logic             err_o,
  input  logic             err_clr_i,
  output logic [7:0]       spurious_cnt_o
);
  localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_state_next;
  logic [1:0]       r_id;
  logic [7:0]       r_hold_cnt;
  logic [7:0]       r_spur_cnt;
  logic             r_err;
  logic             r_bus_req;
  logic             r_irq_valid;

  logic             w_start;
  logic             w_we;
  logic [WB_AW-1:0] w_addr;
  logic [WB_DW-1:0] w_wdata;
  logic             w_done;
  logic             w_timeout;
  logic [1:0]       w_claim_id;
  logic             w_claim_ack;
  logic             w_unused_rdata;

  assign w_claim_id     = plic_wbm_rdata_i[1:0];
  assign w_unused_rdata = ^plic_wbm_rdata_i[WB_DW-1:2];
  assign w_claim_ack    = (r_state == S_CLAIM) && w_done;

  // The bus engine is loaded in the same edge the FSM enters CLAIM/COMPLETE.
  assign w_we    = (r_state == S_ARB_W);
  assign w_start = bus_gnt_i && ((r_state == S_ARB_C) || (r_state == S_ARB_W));
  assign w_addr  = w_we ? COMPLETE_ADDR : CLAIM_ADDR;
  assign w_wdata = w_we ? {{(WB_DW-2){1'b0}}, r_id} : '0;

  wb_single_master #(
    .TIMEOUT (TIMEOUT)
  ) u_wb (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_start),
    .i_we      (w_we),
    .i_addr    (w_addr),
    .i_wdata   (w_wdata),
    .i_ack     (plic_wbm_ack_i),
    .o_cyc     (wbm_plic_cyc_o),
    .o_stb     (wbm_plic_stb_o),
    .o_we      (wbm_plic_we_o),
    .o_addr    (wbm_plic_addr_o),
    .o_wdata   (wbm_plic_wdata_o),
    .o_sel     (wbm_plic_sel_o),
    .o_done    (w_done),
    .o_timeout (w_timeout)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (plic_core_ext_irq_i && irq_en_i) w_state_next = S_ARB_C;
      S_ARB_C:    if (bus_gnt_i) w_state_next = S_CLAIM;
      S_CLAIM: begin
        if (w_done)         w_state_next = (w_claim_id == IRQ_ID_NONE) ? S_HOLD : S_DISPATCH;
        else if (w_timeout) w_state_next = S_HOLD;
      end
      S_DISPATCH: if (irq_ready_i) w_state_next = S_SERVICE;
      S_SERVICE:  if (irq_done_i) w_state_next = S_ARB_W;
      S_ARB_W:    if (bus_gnt_i) w_state_next = S_COMPLETE;
      S_COMPLETE: if (w_done || w_timeout) w_state_next = S_HOLD;
      S_HOLD:     if (r_hold_cnt == HOLD_LAST) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_id        <= IRQ_ID_NONE;
      r_hold_cnt  <= '0;
      r_spur_cnt  <= '0;
      r_err       <= 1'b0;
      r_bus_req   <= 1'b0;
      r_irq_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bus_req   <= (w_state_next == S_ARB_C) || (w_state_next == S_CLAIM) ||
                     (w_state_next == S_ARB_W) || (w_state_next == S_COMPLETE);
      r_irq_valid <= (w_state_next == S_DISPATCH);
      r_hold_cnt  <= (r_state == S_HOLD) ? r_hold_cnt + 8'd1 : 8'd0;
      if (w_claim_ack) r_id <= w_claim_id;
      if (w_claim_ack && (w_claim_id == IRQ_ID_NONE) && (r_spur_cnt != 8'hFF))
        r_spur_cnt <= r_spur_cnt + 8'd1;
      // A timeout in the same cycle as a clear request leaves the error set.
      if (w_timeout)      r_err <= 1'b1;
      else if (err_clr_i) r_err <= 1'b0;
    end
  end

  assign bus_req_o      = r_bus_req;
  assign irq_valid_o    = r_irq_valid;
  assign irq_id_o       = r_id;
  assign err_o          = r_err;
  assign spurious_cnt_o = r_spur_cnt;
endmodule

// File: tb/tb_plic_claim_master.sv
// Scoreboard bench for plic_claim_master: stimulus queues expected bus cycles
// and dispatches; a negedge monitor pops and compares as the DUT produces them.
module tb_plic_claim_master;
  import plic_claim_master_pkg::*;

  localparam logic [31:0] CLAIM_A = 32'h0C20_0004;
  localparam logic [31:0] COMPL_A = 32'h0C20_0008;
  localparam int          TMO     = 255;
  localparam int          HOLDN   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        irq = 1'b0, irq_en = 1'b1, gnt = 1'b0, ack = 1'b0;
  logic        ready = 1'b0, done = 1'b0, err_clr = 1'b0;
  logic [31:0] rdata = '0;
  logic        bus_req, cyc, stb, we, valid, err;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic [1:0]  id;
  logic [7:0]  spur;

  int n_checks = 0;
  int n_fail   = 0;

  plic_claim_master #(
    .CLAIM_ADDR    (CLAIM_A),
    .COMPLETE_ADDR (COMPL_A),
    .TIMEOUT       (TMO),
    .HOLDOFF       (HOLDN)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .plic_core_ext_irq_i (irq),
    .irq_en_i            (irq_en),
    .bus_req_o           (bus_req),
    .bus_gnt_i           (gnt),
    .wbm_plic_cyc_o      (cyc),
    .wbm_plic_stb_o      (stb),
    .wbm_plic_we_o       (we),
    .wbm_plic_addr_o     (addr),
    .wbm_plic_wdata_o    (wdata),
    .wbm_plic_sel_o      (sel),
    .plic_wbm_rdata_i    (rdata),
    .plic_wbm_ack_i      (ack),
    .irq_valid_o         (valid),
    .irq_id_o            (id),
    .irq_ready_i         (ready),
    .irq_done_i          (done),
    .err_o               (err),
    .err_clr_i           (err_clr),
    .spurious_cnt_o      (spur)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name, input int limit);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no response within %0d cycles", name, limit);
  endtask

  // ---------------- arbiter + PLIC slave model ----------------
  int          gnt_delay = 0, gnt_wait = 0, ack_delay = 1, ack_wait = 0;
  bit          ack_on = 1'b1;
  logic [31:0] claim_rdata = '0;

  always @(negedge clk) begin
    if (!bus_req) begin
      gnt = 1'b0; gnt_wait = 0;
    end else if (!gnt) begin
      if (gnt_wait >= gnt_delay) gnt = 1'b1;
      else gnt_wait++;
    end
    ack = 1'b0; rdata = '0;
    if (cyc && stb && ack_on) begin
      if (ack_wait >= ack_delay) begin
        ack = 1'b1; rdata = we ? 32'h0 : claim_rdata; ack_wait = 0;
      end else ack_wait++;
    end else ack_wait = 0;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_bus;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_bus(input bit w, input logic [31:0] a, input logic [31:0] d, input bit cd);
    exp_t e;
    e.is_bus = 1'b1; e.we = w; e.addr = a; e.data = d; e.chk_data = cd;
    exp_q.push_back(e);
  endtask

  task automatic push_disp(input logic [1:0] i);
    exp_t e;
    e.is_bus = 1'b0; e.we = 1'b0; e.addr = '0; e.data = {30'd0, i}; e.chk_data = 1'b1;
    exp_q.push_back(e);
  endtask

  logic        prev_cyc = 1'b0, prev_valid = 1'b0;
  logic [69:0] snap = '0;
  bit          unstable = 1'b0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (cyc && !prev_cyc) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL bus_unexpected: got cycle we=%0b addr=%0h expected none", we, addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("ev_is_bus", 64'(mon_e.is_bus), 64'd1);
        check("bus_we", 64'(we), 64'(mon_e.we));
        check("bus_addr", 64'(addr), 64'(mon_e.addr));
        if (mon_e.chk_data) check("bus_wdata", 64'(wdata), 64'(mon_e.data));
        check("bus_sel_stb", 64'({sel, stb}), 64'({4'hF, 1'b1}));
      end
      snap = {stb, we, sel, addr, wdata};
    end else if (cyc && prev_cyc && ({stb, we, sel, addr, wdata} !== snap)) begin
      unstable = 1'b1;
    end
    if (!cyc && prev_cyc) begin
      check("bus_hold_stable", 64'(unstable), 64'd0);
      unstable = 1'b0;
    end
    if (valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL disp_unexpected: got id %0d expected none", id);
      end else begin
        mon_e = exp_q.pop_front();
        check("ev_is_disp", 64'(mon_e.is_bus), 64'd0);
        check("disp_id", 64'(id), 64'(mon_e.data));
      end
    end
    prev_cyc   = cyc;
    prev_valid = valid;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, 64'({bus_req, cyc, stb, we, sel}), 64'd0);
    check({tag, "_addr"}, 64'(addr), 64'd0);
    check({tag, "_wdata"}, 64'(wdata), 64'd0);
    check({tag, "_irq"}, 64'({valid, id}), 64'd0);
    check({tag, "_err_spur"}, 64'({err, spur}), 64'd0);
  endtask

  task automatic raise_and_claim(input int gd, input int ad, input bit on, input logic [31:0] rv,
                                 output int arb_n, output int req_low, output int hi_n);
    gnt_delay = gd; ack_delay = ad; ack_on = on; claim_rdata = rv;
    irq = 1'b1;
    arb_n = 0; req_low = 0; hi_n = 0;
    do begin
      @(negedge clk);
      if (!cyc) begin
        arb_n++;
        if (!bus_req) req_low++;
      end
    end while (!cyc && arb_n < 400);
    if (!cyc) begin
      timeout_fail("claim_start", 400);
      irq = 1'b0;
      return;
    end
    while (cyc && hi_n < 400) begin
      hi_n++;
      @(negedge clk);
    end
    if (cyc) timeout_fail("claim_end", 400);
    irq = 1'b0;
  endtask

  task automatic dispatch(input logic [1:0] exp_id);
    int n = 0;
    while (!valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!valid) begin
      timeout_fail("dispatch_valid", 20);
      return;
    end
    done = 1'b1;            // stray handler-done while still dispatching
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    check("dispatch_held", 64'({valid, id}), 64'({1'b1, exp_id}));
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("dispatch_drop", 64'(valid), 64'd0);
  endtask

  task automatic complete_and_hold();
    int n = 0;
    int bad = 0;
    tick(2);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    while (!cyc && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cyc) begin
      timeout_fail("complete_start", 20);
      return;
    end
    n = 0;
    while (cyc && n < 400) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (dut.r_state == S_HOLD && n < 10) begin
      if (({bus_req, cyc, stb, we, sel} != 0) || (addr != 0) || (wdata != 0)) bad++;
      n++;
      @(negedge clk);
    end
    check("hold_cycles", 64'(n), 64'(HOLDN));
    check("hold_bus_idle", 64'(bad), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int arb_n, req_low, hi_n, act;

    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(2);

    // GPIO claim with immediate grant, ack after one cycle
    push_bus(1'b0, CLAIM_A, 32'h0, 1'b0);
    push_disp(2'd2);
    push_bus(1'b1, COMPL_A, 32'h2, 1'b1);
    raise_and_claim(0, 1, 1'b1, 32'h2, arb_n, req_low, hi_n);
    check("basic_arb_cycles", 64'(arb_n), 64'd1);
    check("basic_claim_cycles", 64'(hi_n), 64'd2);
    dispatch(2'd2);
    complete_and_hold();

    // UART claim with grant delayed by 5 cycles; upper rdata bits ignored
    push_bus(1'b0, CLAIM_A, 32'h0, 1'b0);
    push_disp(2'd1);
    push_bus(1'b1, COMPL_A, 32'h1, 1'b1);
    raise_and_claim(5, 2, 1'b1, 32'hFFFF_FFF1, arb_n, req_low, hi_n);
    check("gnt_wait_cycles", 64'(arb_n), 64'd6);
    check("gnt_wait_req_held", 64'(req_low), 64'd0);
    check("gnt_claim_cycles", 64'(hi_n), 64'd3);
    dispatch(2'd1);
    complete_and_hold();

    // Spurious claim: no dispatch, no complete
    push_bus(1'b0, CLAIM_A, 32'h0, 1'b0);
    raise_and_claim(0, 1, 1'b1, 32'h0, arb_n, req_low, hi_n);
    tick(6);
    check("spur_first", 64'(spur), 64'd1);
    check("spur_no_dispatch", 64'(valid), 64'd0);
    for (int k = 0; k < 254; k++) begin
      push_bus(1'b0, CLAIM_A, 32'h0, 1'b0);
      raise_and_claim(0, 0, 1'b1, 32'h4, arb_n, req_low, hi_n);
    end
    tick(6);
    check("spur_255", 64'(spur), 64'd255);
    push_bus(1'b0, CLAIM_A, 32'h0, 1'b0);
    raise_and_claim(0, 0, 1'b1, 32'h0, arb_n, req_low, hi_n);
    tick(6);
    check("spur_saturate", 64'(spur), 64'd255);

    // Claim never acknowledged
    push_bus(1'b0, CLAIM_A, 32'h0, 1'b0);
    raise_and_claim(0, 0, 1'b0, 32'h2, arb_n, req_low, hi_n);
    check("tmo_cyc_cycles", 64'(hi_n), 64'(TMO));
    check("tmo_err_set", 64'({err, bus_req}), 64'({1'b1, 1'b0}));
    tick(5);
    check("tmo_no_dispatch", 64'({valid, err}), 64'({1'b0, 1'b1}));
    ack_on = 1'b1;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", 64'(err), 64'd0);

    // Interrupt masked, then enabled; enable drops mid-sequence
    irq_en = 1'b0;
    irq = 1'b1;
    act = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus_req || cyc) act++;
    end
    check("masked_no_activity", 64'(act), 64'd0);
    push_bus(1'b0, CLAIM_A, 32'h0, 1'b0);
    push_disp(2'd2);
    push_bus(1'b1, COMPL_A, 32'h2, 1'b1);
    gnt_delay = 0; ack_delay = 1; claim_rdata = 32'h2;
    irq_en = 1'b1;
    act = 0;
    do begin
      @(negedge clk);
      act++;
    end while (!cyc && act < 20);
    check("enable_to_claim", 64'(act), 64'd2);
    irq_en = 1'b0;
    act = 0;
    while (cyc && act < 20) begin
      @(negedge clk);
      act++;
    end
    irq = 1'b0;
    dispatch(2'd2);
    complete_and_hold();
    irq_en = 1'b1;

    // Reset while the complete write is in flight
    push_bus(1'b0, CLAIM_A, 32'h0, 1'b0);
    push_disp(2'd1);
    push_bus(1'b1, COMPL_A, 32'h1, 1'b1);
    raise_and_claim(0, 1, 1'b1, 32'h1, arb_n, req_low, hi_n);
    ack_on = 1'b0;
    dispatch(2'd1);
    tick(1);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    act = 0;
    while (!cyc && act < 20) begin
      @(negedge clk);
      act++;
    end
    tick(3);
    check("complete_inflight", 64'({cyc, stb, we}), 64'({1'b1, 1'b1, 1'b1}));
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    check("midrst_state", 64'(dut.r_state), 64'(S_IDLE));
    rst = 1'b0;
    ack_on = 1'b1;
    tick(2);

    // Normal service after the reset
    push_bus(1'b0, CLAIM_A, 32'h0, 1'b0);
    push_disp(2'd2);
    push_bus(1'b1, COMPL_A, 32'h2, 1'b1);
    raise_and_claim(0, 2, 1'b1, 32'h2, arb_n, req_low, hi_n);
    check("post_rst_arb", 64'(arb_n), 64'd1);
    dispatch(2'd2);
    complete_and_hold();

    tick(5);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/plic_claim_master.md
Name: plic_claim_master

Overview:
- Hardware interrupt claim/complete sequencer on the core side of the PLIC. It is the Wishbone initiator that talks to the PLIC's claim and complete registers.
- When the PLIC external-interrupt line rises, the block:
  1. arbitrates for the shared peripheral bus;
  2. reads the claim register;
  3. hands the interrupt ID to the core;
  4. waits for the handler to finish;
  5. writes the ID back to the complete register.
- It sits between the PLIC, the core's trap logic and the Wishbone bus arbiter.

Parameters:
- CLAIM_ADDR, `IRQ_RESPONSE_ADDR, Wishbone address of the PLIC claim register.
- COMPLETE_ADDR, `IRQ_COMPLETE_ADDR, Wishbone address of the PLIC complete register.
- TIMEOUT, 255, maximum cycles waiting for ack per transaction (8-bit counter).
- HOLDOFF, 2, idle cycles after a complete before the IRQ line is sampled again.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- plic_core_ext_irq_i  in  1  PLIC external interrupt request (level)
- irq_en_i  in  1  core global external-interrupt enable (mie.MEIE & mstatus.MIE)
- bus_req_o  out  1  request for the shared Wishbone bus
- bus_gnt_i  in  1  grant from the arbiter
- wbm_plic_cyc_o  out  1  Wishbone cyc
- wbm_plic_stb_o  out  1  Wishbone stb
- wbm_plic_we_o  out  1  Wishbone write enable
- wbm_plic_addr_o  out  `WB_AD_WIDTH  Wishbone address
- wbm_plic_wdata_o  out  `WB_DAT_WIDTH  Wishbone write data
- wbm_plic_sel_o  out  `WB_DAT_WIDTH/8  byte select, always all-ones when stb is high
- plic_wbm_rdata_i  in  `WB_DAT_WIDTH  Wishbone read data
- plic_wbm_ack_i  in  1  Wishbone ack
- irq_valid_o  out  1  claimed interrupt presented to the core
- irq_id_o  out  2  claimed ID (1 = uart, 2 = gpio)
- irq_ready_i  in  1  core accepts the trap
- irq_done_i  in  1  single-cycle pulse: handler finished (mret)
- err_o  out  1  sticky bus-timeout error
- err_clr_i  in  1  clears err_o
- spurious_cnt_o  out  8  saturating count of claims that returned ID 0

Behaviour:
- Reset (synchronous): every output is 0, state = IDLE, id register = 0, timeout counter = 0. A bus cycle in flight is dropped in the same edge.
- State machine states: IDLE, ARB_C, CLAIM, DISPATCH, SERVICE, ARB_W, COMPLETE, HOLD.
- IDLE:
  - Go to ARB_C when plic_core_ext_irq_i && irq_en_i.
  - In ARB_C, bus_req_o = 1; go to CLAIM on bus_gnt_i.
- CLAIM:
  - Drive cyc = stb = 1, we = 0, addr = CLAIM_ADDR, sel = all-ones.
  - When ack is sampled high: capture rdata[1:0] into the id register, and deassert cyc, stb and bus_req_o from that edge (single beat, no back-to-back).
  - If the captured ID is 0: increment spurious_cnt_o (saturating at 255) and go to HOLD.
  - Otherwise go to DISPATCH.
- DISPATCH:
  - irq_valid_o = 1 and irq_id_o = the id register, both held stable until irq_ready_i.
  - On irq_ready_i go to SERVICE, and irq_valid_o drops at the next edge.
- SERVICE:
  - Wait for irq_done_i, then go to ARB_W.
  - plic_core_ext_irq_i is ignored throughout: no nesting.
- ARB_W / COMPLETE:
  - Request and grant work as in ARB_C.
  - Drive cyc = stb = 1, we = 1, addr = COMPLETE_ADDR, wdata = {zeros, id}.
  - On ack, deassert everything and go to HOLD.
  - The completion is always issued for the exact ID that was claimed.
- Timeout:
  - The counter runs while in CLAIM or COMPLETE and clears on entry to either state.
  - If the count reaches TIMEOUT with no ack: drop cyc, stb and req, set err_o, and go to HOLD. A timed-out claim is never dispatched.
- HOLD: stay for HOLDOFF cycles with all bus outputs 0, then go to IDLE. This guarantees idle gaps between PLIC transactions.
- Bus hold rules:
  - cyc, stb, we, addr, wdata and sel are registered and stay constant from assertion until ack or timeout.
  - bus_req_o stays high from ARB entry until the transaction ends.
  - Losing grant mid-transaction is not allowed; the arbiter holds grant while bus_req_o is high.
- err_o: set by timeout, cleared by err_clr_i. If both occur in the same cycle, set wins.
- An irq_done_i outside SERVICE is ignored.
- If irq_en_i falls after a claim, the sequence still completes; it is sampled only in IDLE.

Decomposition:
- Shared header perips_cfg.vh supplies the address and width defines (WB_AD_WIDTH, WB_DAT_WIDTH, IRQ_RESPONSE_ADDR, IRQ_COMPLETE_ADDR).
- The state encoding and the IRQ ID values (UART = 1, GPIO = 2, NONE = 0) are added there as defines.
- One sub-module, wb_single_master: a single-beat Wishbone initiator with a timeout counter, used for both the claim and the complete transaction.

Test Plan:
- Raise the IRQ, grant immediately, PLIC acks the claim after 1 cycle with rdata = 2 → irq_valid_o = 1 with irq_id_o = 2. After irq_ready_i then irq_done_i → one write to COMPLETE_ADDR with wdata = 2, then HOLD for 2 cycles.
- Delay bus_gnt_i by 5 cycles → cyc stays 0 until grant, and bus_req_o stays high for the whole wait.
- Claim returns rdata = 0 → no irq_valid_o, no complete write, spurious_cnt_o = 1. After 256 such claims it reads 255.
- Never ack the claim → after 255 cycles cyc drops, err_o = 1, no dispatch. err_clr_i then clears err_o.
- Hold irq_en_i = 0 with the IRQ high → no bus activity. Raise irq_en_i → claim within 2 cycles.
- Assert rst during COMPLETE with stb high → next cycle all outputs 0, state = IDLE, and a new IRQ is serviced normally.
